// File: rtl/i2c_arbiter_if.sv
// Requester-side and driver-side signals of the two-port I2C arbiter.
// Handshake: a requester raises reqN with its fields stable and holds them
// until doneN pulses for one cycle (errN is valid only alongside doneN);
// toward the driver, i2c_exec is a one-cycle trigger with the i2c_* fields
// valid in that cycle, and i2c_done is a one-cycle completion with i2c_data_r.
interface i2c_arbiter_if;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        rh_wl0, rh_wl1;
  logic        bit_ctrl0, bit_ctrl1;
  logic        done0, done1;
  logic        err0, err1;
  logic [7:0]  rdata0, rdata1;
  logic        busy;
  logic        i2c_exec;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic        i2c_rh_wl;
  logic        i2c_bit_ctrl;
  logic        i2c_done;
  logic [7:0]  i2c_data_r;

  // Arbiter view: serves the requesters, drives the I2C driver.
  modport master (
    input  req0, req1, addr0, addr1, wdata0, wdata1,
    input  rh_wl0, rh_wl1, bit_ctrl0, bit_ctrl1,
    output done0, done1, err0, err1, rdata0, rdata1, busy,
    output i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl, i2c_bit_ctrl,
    input  i2c_done, i2c_data_r
  );

  // Environment view: requesters plus the I2C driver.
  modport slave (
    output req0, req1, addr0, addr1, wdata0, wdata1,
    output rh_wl0, rh_wl1, bit_ctrl0, bit_ctrl1,
    input  done0, done1, err0, err1, rdata0, rdata1, busy,
    input  i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl, i2c_bit_ctrl,
    output i2c_done, i2c_data_r
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C driver between two requesters.
// One transaction outstanding at a time; all outputs are registered.
module i2c_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic          clk,
  input  logic          rst_n,
  i2c_arbiter_if.master bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        owner;
  logic [15:0] wait_cnt;
  logic        grant_valid;
  logic        grant_port;
  logic        timed_out;
  logic        finish;
  logic        exec_nxt;
  logic        busy_nxt;

  // The counter is cleared in ISSUE and counts WAIT cycles; the abort is
  // decided TIMEOUT+1 cycles into WAIT so done/err=1 lands TIMEOUT+2 cycles
  // after i2c_exec.
  assign timed_out = (wait_cnt == TIMEOUT);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and round-robin grant decision.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_valid = 1'b1;
          if (bus.req0 && bus.req1) grant_port = ~last;
          else                      grant_port = bus.req1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (bus.i2c_done || timed_out) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; i2c_done beats the timeout.
  always_comb begin
    exec_nxt = (state_nxt == S_ISSUE);
    busy_nxt = (state_nxt != S_IDLE);
    finish   = (state == S_WAIT) && (state_nxt == S_RELEASE);
  end

  // Output, field-latch, owner and timeout-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i2c_exec     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done0        <= 1'b0;
      bus.done1        <= 1'b0;
      bus.err0         <= 1'b0;
      bus.err1         <= 1'b0;
      bus.rdata0       <= 8'h00;
      bus.rdata1       <= 8'h00;
      bus.i2c_addr     <= 16'h0000;
      bus.i2c_data_w   <= 8'h00;
      bus.i2c_rh_wl    <= 1'b0;
      bus.i2c_bit_ctrl <= 1'b0;
      last             <= 1'b1;
      owner            <= 1'b0;
      wait_cnt         <= 16'h0000;
    end else begin
      bus.i2c_exec <= exec_nxt;
      bus.busy     <= busy_nxt;
      bus.done0    <= finish && (owner == 1'b0);
      bus.done1    <= finish && (owner == 1'b1);
      bus.err0     <= finish && (owner == 1'b0) && !bus.i2c_done;
      bus.err1     <= finish && (owner == 1'b1) && !bus.i2c_done;
      if (grant_valid) begin
        owner <= grant_port;
        last  <= grant_port;
        if (grant_port) begin
          bus.i2c_addr     <= bus.addr1;
          bus.i2c_data_w   <= bus.wdata1;
          bus.i2c_rh_wl    <= bus.rh_wl1;
          bus.i2c_bit_ctrl <= bus.bit_ctrl1;
        end else begin
          bus.i2c_addr     <= bus.addr0;
          bus.i2c_data_w   <= bus.wdata0;
          bus.i2c_rh_wl    <= bus.rh_wl0;
          bus.i2c_bit_ctrl <= bus.bit_ctrl0;
        end
      end
      if (state == S_ISSUE)     wait_cnt <= 16'h0000;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (finish && bus.i2c_done && bus.i2c_rh_wl) begin
        if (owner) bus.rdata1 <= bus.i2c_data_r;
        else       bus.rdata0 <= bus.i2c_data_r;
      end
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: a long-timeout instance for normal traffic and a
// TIMEOUT=16 instance for the abort path, selected by 'sel'.
module tb_i2c_arbiter;

  localparam int T_LONG  = 50000;
  localparam int T_SHORT = 16;

  logic clk;
  logic rst_n;
  logic sel;

  logic        req_v   [2];
  logic [15:0] addr_v  [2];
  logic [7:0]  wdata_v [2];
  logic        rhwl_v  [2];
  logic        bitc_v  [2];
  logic        drv_done;
  logic [7:0]  drv_rd;

  logic [7:0]  rdata_ref [2][2];
  logic        last_ref  [2];
  logic [0:0]  exp_q [$];

  int checks = 0;
  int errors = 0;

  logic [1:0] st_l, st_s;

  i2c_arbiter_if b ();
  i2c_arbiter_if bt ();

  i2c_arbiter #(.TIMEOUT(16'(T_LONG))) u_dut_long (
    .clk(clk), .rst_n(rst_n), .bus(b.master), .dbg_state(st_l));
  i2c_arbiter #(.TIMEOUT(16'(T_SHORT))) u_dut_short (
    .clk(clk), .rst_n(rst_n), .bus(bt.master), .dbg_state(st_s));

  assign b.req0       = req_v[0] & ~sel;
  assign b.req1       = req_v[1] & ~sel;
  assign bt.req0      = req_v[0] & sel;
  assign bt.req1      = req_v[1] & sel;
  assign b.addr0      = addr_v[0];
  assign b.addr1      = addr_v[1];
  assign bt.addr0     = addr_v[0];
  assign bt.addr1     = addr_v[1];
  assign b.wdata0     = wdata_v[0];
  assign b.wdata1     = wdata_v[1];
  assign bt.wdata0    = wdata_v[0];
  assign bt.wdata1    = wdata_v[1];
  assign b.rh_wl0     = rhwl_v[0];
  assign b.rh_wl1     = rhwl_v[1];
  assign bt.rh_wl0    = rhwl_v[0];
  assign bt.rh_wl1    = rhwl_v[1];
  assign b.bit_ctrl0  = bitc_v[0];
  assign b.bit_ctrl1  = bitc_v[1];
  assign bt.bit_ctrl0 = bitc_v[0];
  assign bt.bit_ctrl1 = bitc_v[1];
  assign b.i2c_done   = drv_done & ~sel;
  assign bt.i2c_done  = drv_done & sel;
  assign b.i2c_data_r  = drv_rd;
  assign bt.i2c_data_r = drv_rd;

  logic        o_exec, o_busy, o_rhwl, o_bitc;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata;
  logic        o_done [2];
  logic        o_err  [2];
  logic [7:0]  o_rdata [2];

  // Observe whichever instance is selected.
  always_comb begin
    o_exec     = sel ? bt.i2c_exec     : b.i2c_exec;
    o_busy     = sel ? bt.busy         : b.busy;
    o_rhwl     = sel ? bt.i2c_rh_wl    : b.i2c_rh_wl;
    o_bitc     = sel ? bt.i2c_bit_ctrl : b.i2c_bit_ctrl;
    o_addr     = sel ? bt.i2c_addr     : b.i2c_addr;
    o_wdata    = sel ? bt.i2c_data_w   : b.i2c_data_w;
    o_done[0]  = sel ? bt.done0  : b.done0;
    o_done[1]  = sel ? bt.done1  : b.done1;
    o_err[0]   = sel ? bt.err0   : b.err0;
    o_err[1]   = sel ? bt.err1   : b.err1;
    o_rdata[0] = sel ? bt.rdata0 : b.rdata0;
    o_rdata[1] = sel ? bt.rdata1 : b.rdata1;
  end

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},   32'(o_busy), 0);
    check({tag, "_exec"},   32'(o_exec), 0);
    check({tag, "_done0"},  32'(o_done[0]), 0);
    check({tag, "_done1"},  32'(o_done[1]), 0);
    check({tag, "_err0"},   32'(o_err[0]), 0);
    check({tag, "_err1"},   32'(o_err[1]), 0);
    check({tag, "_rdata0"}, 32'(o_rdata[0]), 0);
    check({tag, "_rdata1"}, 32'(o_rdata[1]), 0);
    check({tag, "_addr"},   32'(o_addr), 0);
    check({tag, "_wdata"},  32'(o_wdata), 0);
    check({tag, "_rhwl"},   32'(o_rhwl), 0);
    check({tag, "_bitc"},   32'(o_bitc), 0);
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      last_ref[d] = 1'b1;
      for (int p = 0; p < 2; p++) rdata_ref[d][p] = 8'h00;
    end
  endtask

  task automatic rand_fields(input int p);
    addr_v[p]  = 16'($urandom);
    wdata_v[p] = 8'($urandom);
    rhwl_v[p]  = 1'($urandom_range(0, 1));
    bitc_v[p]  = 1'($urandom_range(0, 1));
  endtask

  // Round-robin rule: a lone requester wins; a tie goes to the port not granted last.
  function automatic int pick(input bit q0, input bit q1);
    if (q0 && q1) return last_ref[sel] ? 0 : 1;
    return q1 ? 1 : 0;
  endfunction

  // One transaction for expected port p: driver answers 'lat' cycles after
  // i2c_exec (0 = never). Returns on the negedge where done is expected.
  task automatic serve(input int p, input int lat, input logic [7:0] rd,
                       input bit perturb, input int exp_lat);
    int          d, t, dly, c, q;
    bit          ok;
    logic [15:0] ea;
    logic [7:0]  ew;
    logic        er, eb;
    d  = sel ? 1 : 0;
    t  = sel ? T_SHORT : T_LONG;
    q  = 1 - p;
    ea = addr_v[p]; ew = wdata_v[p]; er = rhwl_v[p]; eb = bitc_v[p];
    ok  = (lat != 0) && (lat <= t + 1);
    dly = ok ? lat + 1 : t + 2;
    c = 0;
    while (o_exec !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("exec_seen", 32'(o_exec), 1);
    if (o_exec !== 1'b1) return;
    check("exec_latency", 32'(c), 32'(exp_lat));
    check("i2c_addr",  32'(o_addr), 32'(ea));
    check("i2c_wdata", 32'(o_wdata), 32'(ew));
    check("i2c_rhwl",  32'(o_rhwl), 32'(er));
    check("i2c_bitc",  32'(o_bitc), 32'(eb));
    last_ref[d] = p[0];
    if (ok && er) rdata_ref[d][p] = rd;
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      check("exec_single", 32'(o_exec), 0);
      check("other_done", 32'(o_done[q]), 0);
      if (perturb) check("addr_hold", 32'(o_addr), 32'(ea));
      if (k < dly) begin
        check("done_early", 32'(o_done[p]), 0);
        check("busy_txn", 32'(o_busy), 1);
      end else begin
        check("done_owner", 32'(o_done[p]), 1);
        check("err_owner", 32'(o_err[p]), ok ? 0 : 1);
        check("rdata0", 32'(o_rdata[0]), 32'(rdata_ref[d][0]));
        check("rdata1", 32'(o_rdata[1]), 32'(rdata_ref[d][1]));
      end
      drv_done = (k == lat);
      drv_rd   = (k == lat) ? rd : 8'($urandom);
      if (perturb && k == 2) begin
        addr_v[p]  = ~ea;
        wdata_v[p] = ~ew;
      end
    end
    drv_done = 1'b0;
  endtask

  // Directed sequence with randomized fields and driver latencies.
  initial begin
    int p, c;
    int left [2];
    bit lastm;
    logic [1:0] qr;
    sel = 1'b0; rst_n = 1'b0; drv_done = 1'b0; drv_rd = 8'h00;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; rhwl_v[i] = 1'b0; bitc_v[i] = 1'b0;
    end
    reset_model();
    repeat (3) @(negedge clk);
    check_reset("rst_long");
    sel = 1'b1; #1;
    check_reset("rst_short");
    sel = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single write on port 0, driver answers after 40 cycles.
    addr_v[0] = 16'h0003; wdata_v[0] = 8'h6D; rhwl_v[0] = 1'b0; bitc_v[0] = 1'b0;
    req_v[0] = 1'b1;
    serve(pick(1, 0), 40, 8'($urandom), 0, 1);
    req_v[0] = 1'b0;

    // Read on port 1 returning A5.
    rand_fields(1); rhwl_v[1] = 1'b1; req_v[1] = 1'b1;
    serve(pick(0, 1), $urandom_range(1, 30), 8'hA5, 0, 2);
    check("rdata1_a5", 32'(o_rdata[1]), 32'h A5);
    req_v[1] = 1'b0;

    // Contention from reset: three transactions per port.
    rst_n = 1'b0; rand_fields(0); rand_fields(1);
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    left[0] = 3; left[1] = 3; lastm = last_ref[0];
    while (left[0] + left[1] > 0) begin
      if (left[0] > 0 && left[1] > 0) p = lastm ? 0 : 1;
      else p = (left[0] > 0) ? 0 : 1;
      exp_q.push_back(1'(p));
      lastm = p[0];
      left[p]--;
    end
    left[0] = 3; left[1] = 3; c = 0;
    while (exp_q.size() > 0) begin
      p = int'(exp_q.pop_front());
      serve(p, $urandom_range(1, 25), 8'($urandom), 0, (c == 0) ? 1 : 2);
      c++;
      left[p]--;
      if (left[p] == 0) req_v[p] = 1'b0;
      else rand_fields(p);
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;

    // Random request patterns.
    for (int i = 0; i < 6; i++) begin
      qr = 2'($urandom_range(1, 3));
      req_v[0] = qr[0]; req_v[1] = qr[1];
      if (qr[0]) rand_fields(0);
      if (qr[1]) rand_fields(1);
      serve(pick(qr[0], qr[1]), $urandom_range(1, 60), 8'($urandom), 0, 2);
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;

    // Field changes during WAIT, then a stray i2c_done while IDLE.
    rand_fields(0); rhwl_v[0] = 1'b1; req_v[0] = 1'b1;
    serve(pick(1, 0), 20, 8'($urandom), 1, 2);
    req_v[0] = 1'b0;
    @(negedge clk);
    drv_done = 1'b1; drv_rd = 8'($urandom);
    @(negedge clk);
    drv_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stray_done0", 32'(o_done[0]), 0);
      check("stray_done1", 32'(o_done[1]), 0);
      check("stray_busy", 32'(o_busy), 0);
      check("stray_rdata0", 32'(o_rdata[0]), 32'(rdata_ref[0][0]));
      @(negedge clk);
    end

    // Timeout on the TIMEOUT=16 instance, then a normal transaction.
    sel = 1'b1;
    rand_fields(0); rhwl_v[0] = 1'b1; req_v[0] = 1'b1;
    serve(pick(1, 0), 0, 8'h00, 0, 1);
    req_v[0] = 1'b0;
    @(negedge clk);
    check("timeout_idle", 32'(o_busy), 0);
    rand_fields(1); req_v[1] = 1'b1;
    serve(pick(0, 1), 5, 8'($urandom), 0, 1);
    req_v[1] = 1'b0;
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // Reset asserted mid-WAIT.
    rand_fields(0); req_v[0] = 1'b1;
    c = 0;
    while (o_exec !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("rst_exec_seen", 32'(o_exec), 1);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    reset_model();
    req_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_done0", 32'(o_done[0]), 0);
      check("post_rst_done1", 32'(o_done[1]), 0);
      check("post_rst_busy", 32'(o_busy), 0);
    end

    // First tie after reset goes to port 0.
    rand_fields(0); rand_fields(1);
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    serve(pick(1, 1), $urandom_range(1, 20), 8'($urandom), 0, 1);
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
